// File: rtl/tetris_pkg.sv
// tetris_pkg: shared state encoding, command codes and piece shapes
package tetris_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_ACTIVE,
        S_LOCK,
        S_CLEAR,
        S_GAMEOVER
    } state_t;

    localparam logic [1:0] CMD_LEFT   = 2'd0;
    localparam logic [1:0] CMD_RIGHT  = 2'd1;
    localparam logic [1:0] CMD_ROTATE = 2'd2;
    localparam logic [1:0] CMD_DOWN   = 2'd3;

    // 2x2 box mask, bit0=TL bit1=TR bit2=BL bit3=BR
    function automatic logic [3:0] piece_mask(input logic [1:0] ptype, input logic [1:0] rot);
        return ptype == 2'd0 ? 4'b0001 :
               ptype == 2'd1 ? (rot[0] ? 4'b0101 : 4'b0011) :
               ptype == 2'd2 ? ~(4'b0001 << rot) :
                               4'b1111;
    endfunction

endpackage

// File: rtl/tetris_dp_gen_piece_fit.sv
// piece_fit: checks a 2x2-box placement against the board edges and settled cells
module piece_fit
    import tetris_pkg::*;
#(
    parameter int COLS = 4,
    parameter int ROWS = 8
) (
    input  logic [COLS*ROWS-1:0]    board,
    input  logic [1:0]              ptype,
    input  logic [1:0]              rot,
    input  logic [$clog2(COLS):0]   x,
    input  logic [$clog2(ROWS):0]   y,
    output logic                    fits
);

    logic [3:0]           mask;
    logic [COLS*ROWS-1:0] sh;
    int                   cx, cy;

    // a set cell fails if it leaves the board or lands on a settled cell
    always_comb begin
        mask = piece_mask(ptype, rot);
        fits = 1'b1;
        cx   = 0;
        cy   = 0;
        sh   = '0;
        for (int c = 0; c < 4; c++) begin
            cx = int'(x) + c % 2;
            cy = int'(y) + c / 2;
            sh = board >> (cy * COLS + cx);
            if (mask[c] && (cx >= COLS || cy >= ROWS || sh[0])) fits = 1'b0;
        end
    end

endmodule

// File: rtl/tetris_dp_gen.sv
// tetris_dp_gen: falling-piece game datapath with move/gravity handling and row clearing
module tetris_dp_gen
    import tetris_pkg::*;
#(
    parameter int COLS    = 4,
    parameter int ROWS    = 8,
    parameter int LINES_W = 16
) (
    input  logic                     clka,
    input  logic                     restart_n,
    input  logic                     start,
    input  logic [1:0]               piece_in,
    input  logic                     tick,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    output logic [COLS*ROWS-1:0]     board_out,
    output logic [$clog2(COLS)-1:0]  piece_x,
    output logic [$clog2(ROWS)-1:0]  piece_y,
    output logic [1:0]               rotation_out,
    output logic [1:0]               curr_piece_out,
    output logic                     landed,
    output logic [LINES_W-1:0]       lines_total,
    output logic                     game_over
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int N  = COLS * ROWS;
    localparam logic [XW:0] SPAWN_X = (XW + 1)'((COLS - 2) / 2);

    state_t                     state, n_state;
    logic [ROWS-1:0][COLS-1:0]  settled, n_settled;
    logic [XW-1:0]              n_x;
    logic [YW-1:0]              n_y, scan, n_scan;
    logic [1:0]                 n_rot, n_type, op, fr, ft;
    logic [LINES_W-1:0]         n_lines;
    logic                       pend, n_pend, do_op, fits;
    logic [XW:0]                fx;
    logic [YW:0]                fy;

    function automatic logic [N-1:0] place(input logic [1:0] t, input logic [1:0] r,
                                           input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [3:0] m;
        m = piece_mask(t, r);
        place = '0;
        for (int c = 0; c < 4; c++)
            if (m[c]) place |= N'(1) << ((int'(y) + c / 2) * COLS + int'(x) + c % 2);
    endfunction

    // candidate placement: the spawn position in SPAWN, else the requested move (a command beats gravity)
    always_comb begin
        do_op = state == S_ACTIVE && (cmd_valid || pend || tick);
        op    = cmd_valid ? cmd : CMD_DOWN;
        ft    = state == S_SPAWN ? piece_in : curr_piece_out;
        fr    = state == S_SPAWN ? 2'd0 : (op == CMD_ROTATE ? rotation_out + 2'd1 : rotation_out);
        fx    = state == S_SPAWN ? SPAWN_X :
                op == CMD_LEFT   ? {1'b0, piece_x} - 1'b1 :
                op == CMD_RIGHT  ? {1'b0, piece_x} + 1'b1 : {1'b0, piece_x};
        fy    = state == S_SPAWN ? '0 : (op == CMD_DOWN ? {1'b0, piece_y} + 1'b1 : {1'b0, piece_y});
    end

    piece_fit #(.COLS(COLS), .ROWS(ROWS)) u_fit (
        .board (settled),
        .ptype (ft),
        .rot   (fr),
        .x     (fx),
        .y     (fy),
        .fits  (fits)
    );

    // next-state logic for the game sequencer and the settled board
    always_comb begin
        n_state   = state;
        n_settled = settled;
        n_x       = piece_x;
        n_y       = piece_y;
        n_rot     = rotation_out;
        n_type    = curr_piece_out;
        n_pend    = 1'b0;
        n_lines   = lines_total;
        n_scan    = scan;
        case (state)
            S_IDLE, S_GAMEOVER: begin
                if (start) begin
                    n_state   = S_SPAWN;
                    n_settled = '0;
                    n_lines   = state == S_IDLE ? '0 : lines_total;
                end
            end
            S_SPAWN: begin
                n_type  = piece_in;
                n_rot   = 2'd0;
                n_x     = SPAWN_X[XW-1:0];
                n_y     = '0;
                n_state = fits ? S_ACTIVE : S_GAMEOVER;
            end
            S_ACTIVE: begin
                n_pend = cmd_valid && (pend || tick);
                if (do_op && fits) begin
                    n_x   = fx[XW-1:0];
                    n_y   = fy[YW-1:0];
                    n_rot = fr;
                end else if (do_op && op == CMD_DOWN) begin
                    n_state = S_LOCK;
                    n_pend  = 1'b0;
                end
            end
            S_LOCK: begin
                n_settled = settled | place(curr_piece_out, rotation_out, piece_x, piece_y);
                n_scan    = YW'(ROWS - 1);
                n_state   = S_CLEAR;
            end
            S_CLEAR: begin
                if (&settled[scan]) begin
                    for (int i = 1; i < ROWS; i++)
                        if (i <= int'(scan)) n_settled[i] = settled[i-1];
                    n_settled[0] = '0;
                    n_lines      = lines_total + {{(LINES_W-1){1'b0}}, ~&lines_total};
                end else if (scan == '0) begin
                    n_state = S_SPAWN;
                end else begin
                    n_scan = scan - 1'b1;
                end
            end
            default: n_state = S_IDLE;
        endcase
    end

    // state and registered outputs; board_out shows the piece only while it is live
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state          <= S_IDLE;
            settled        <= '0;
            pend           <= 1'b0;
            scan           <= '0;
            cmd_ready      <= 1'b0;
            board_out      <= '0;
            piece_x        <= '0;
            piece_y        <= '0;
            rotation_out   <= '0;
            curr_piece_out <= '0;
            landed         <= 1'b0;
            lines_total    <= '0;
            game_over      <= 1'b0;
        end else begin
            state          <= n_state;
            settled        <= n_settled;
            pend           <= n_pend;
            scan           <= n_scan;
            cmd_ready      <= n_state == S_ACTIVE;
            board_out      <= n_state == S_GAMEOVER ? '1 :
                              (n_state == S_ACTIVE || n_state == S_LOCK) ?
                              n_settled | place(n_type, n_rot, n_x, n_y) : n_settled;
            piece_x        <= n_x;
            piece_y        <= n_y;
            rotation_out   <= n_rot;
            curr_piece_out <= n_type;
            landed         <= state == S_LOCK;
            lines_total    <= n_lines;
            game_over      <= n_state == S_GAMEOVER;
        end
    end

endmodule

// File: tb/tb_tetris_dp_gen.sv
// tb_tetris_dp_gen: directed tables plus random play against a grid-level game model
module tb_tetris_dp_gen;

    localparam int COLS = 4;
    localparam int ROWS = 8;

    logic        clka = 1'b0;
    logic        restart_n, start, tick, cmd_valid;
    logic [1:0]  piece_in, cmd;
    logic        cmd_ready, landed, game_over;
    logic [31:0] board_out;
    logic [1:0]  piece_x, rotation_out, curr_piece_out;
    logic [2:0]  piece_y;
    logic [15:0] lines_total;

    int total = 0;
    int bad   = 0;

    bit grid [ROWS][COLS];
    int mt, mr, mx, my, mlines;
    bit mover, locked;

    typedef struct {
        logic [1:0]  c;
        int          x;
        int          y;
        int          r;
        logic [31:0] b;
    } vec_t;
    vec_t tbl [10];

    tetris_dp_gen dut (
        .clka           (clka),
        .restart_n      (restart_n),
        .start          (start),
        .piece_in       (piece_in),
        .tick           (tick),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .cmd_ready      (cmd_ready),
        .board_out      (board_out),
        .piece_x        (piece_x),
        .piece_y        (piece_y),
        .rotation_out   (rotation_out),
        .curr_piece_out (curr_piece_out),
        .landed         (landed),
        .lines_total    (lines_total),
        .game_over      (game_over)
    );

    always #5 clka = ~clka;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        @(negedge clka);
    endtask

    // shapes as cell lists: cell c sits at column offset c%2, row offset c/2 (TL,TR,BL,BR)
    function automatic bit in_shape(int t, int r, int c);
        case (t)
            0:       return c == 0;
            1:       return (r % 2 == 0) ? (c == 0 || c == 1) : (c == 0 || c == 2);
            2:       return c != r;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit mfits(int t, int r, int x, int y);
        for (int c = 0; c < 4; c++) begin
            if (in_shape(t, r, c)) begin
                if (x + c % 2 < 0 || x + c % 2 >= COLS || y + c / 2 >= ROWS) return 1'b0;
                if (grid[y + c / 2][x + c % 2]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] mboard();
        logic [31:0] b;
        b = '0;
        if (mover) return '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (grid[r][c]) b |= 32'(1) << (r * COLS + c);
        for (int c = 0; c < 4; c++)
            if (in_shape(mt, mr, c)) b |= 32'(1) << ((my + c / 2) * COLS + mx + c % 2);
        return b;
    endfunction

    task automatic mclear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) grid[r][c] = 1'b0;
    endtask

    // settle the piece, then drop every full row and let the rest fall
    task automatic mlock();
        bit ng [ROWS][COLS];
        int dst, cnt, full;
        for (int c = 0; c < 4; c++)
            if (in_shape(mt, mr, c)) grid[my + c / 2][mx + c % 2] = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ng[r][c] = 1'b0;
        dst = ROWS - 1;
        cnt = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1;
            for (int c = 0; c < COLS; c++) if (!grid[r][c]) full = 0;
            if (full != 0) cnt++;
            else begin
                for (int c = 0; c < COLS; c++) ng[dst][c] = grid[r][c];
                dst--;
            end
        end
        grid   = ng;
        mlines = (mlines + cnt > 65535) ? 65535 : mlines + cnt;
    endtask

    task automatic mspawn(input int t);
        mt    = t;
        mr    = 0;
        mx    = (COLS - 2) / 2;
        my    = 0;
        mover = !mfits(t, 0, mx, my);
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".board"}, board_out, mboard());
        chk({nm, ".ready"}, cmd_ready, !mover);
        chk({nm, ".over"}, game_over, mover);
        chk({nm, ".lines"}, lines_total, mlines);
        if (!mover) begin
            chk({nm, ".x"}, piece_x, mx);
            chk({nm, ".y"}, piece_y, my);
            chk({nm, ".rot"}, rotation_out, mr);
            chk({nm, ".type"}, curr_piece_out, mt);
        end
    endtask

    task automatic restart();
        restart_n = 1'b0;
        start = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
        step();
        restart_n = 1'b1;
        mclear();
        mlines = 0;
        mover  = 1'b0;
    endtask

    task automatic startg(input int t);
        piece_in = 2'(t);
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        mclear();
        mlines = 0;
        mspawn(t);
        check_all("start");
    endtask

    // one command (or a lone gravity tick when tk=1), followed through lock and respawn
    task automatic move(input int c, input bit tk, input int nxt);
        int cc, cx, cy, cr, lc;
        piece_in = 2'(nxt);
        if (tk) tick = 1'b1;
        else begin
            cmd_valid = 1'b1;
            cmd       = 2'(c);
        end
        step();
        tick      = 1'b0;
        cmd_valid = 1'b0;
        cc = tk ? 3 : c;
        cx = mx + (cc == 1 ? 1 : 0) - (cc == 0 ? 1 : 0);
        cy = my + (cc == 3 ? 1 : 0);
        cr = (mr + (cc == 2 ? 1 : 0)) % 4;
        locked = 1'b0;
        if (mfits(mt, cr, cx, cy)) begin
            mx = cx; my = cy; mr = cr;
        end else if (cc == 3) begin
            locked = 1'b1;
            lc = 0;
            for (int k = 0; k < 40 && !(cmd_ready || game_over); k++) begin
                step();
                if (landed) lc++;
            end
            chk("lock_done", cmd_ready || game_over, 1);
            chk("landed_pulses", lc, 1);
            mlock();
            mspawn(nxt);
        end
        check_all("move");
    endtask

    task automatic drop(input int tx, input int nxt);
        for (int k = 0; k < COLS && mx < tx; k++) move(1, 1'b0, nxt);
        for (int k = 0; k < COLS && mx > tx; k++) move(0, 1'b0, nxt);
        locked = 1'b0;
        for (int k = 0; k < ROWS + 2 && !locked; k++) move(3, 1'b0, nxt);
        chk("drop_locked", locked, 1);
    endtask

    initial begin
        tbl[0] = '{2'd0, 0, 0, 0, 32'h0000_0001};
        tbl[1] = '{2'd0, 0, 0, 0, 32'h0000_0001};
        tbl[2] = '{2'd1, 1, 0, 0, 32'h0000_0002};
        tbl[3] = '{2'd1, 2, 0, 0, 32'h0000_0004};
        tbl[4] = '{2'd1, 3, 0, 0, 32'h0000_0008};
        tbl[5] = '{2'd1, 3, 0, 0, 32'h0000_0008};
        tbl[6] = '{2'd2, 3, 0, 1, 32'h0000_0008};
        tbl[7] = '{2'd3, 3, 1, 1, 32'h0000_0080};
        tbl[8] = '{2'd3, 3, 2, 1, 32'h0000_0800};
        tbl[9] = '{2'd0, 2, 2, 1, 32'h0000_0400};

        restart_n = 1'b0; start = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
        piece_in = 2'd0; cmd = 2'd0;
        step();
        step();
        chk("rst.board", board_out, 0);
        chk("rst.ready", cmd_ready, 0);
        chk("rst.over", game_over, 0);
        chk("rst.lines", lines_total, 0);
        chk("rst.landed", landed, 0);
        chk("rst.xy", {piece_x, piece_y, rotation_out, curr_piece_out}, 0);

        // square spawns at x=1: cells (1,0),(2,0),(1,1),(2,1)
        restart();
        piece_in = 2'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("spawn.ready", cmd_ready, 0);
        step();
        chk("spawn.x", piece_x, 1);
        chk("spawn.y", piece_y, 0);
        chk("spawn.board", board_out, 32'h0000_0066);
        chk("spawn.ready2", cmd_ready, 1);

        restart();
        startg(0);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            cmd       = tbl[i].c;
            step();
            cmd_valid = 1'b0;
            chk($sformatf("tbl%0d.x", i), piece_x, tbl[i].x);
            chk($sformatf("tbl%0d.y", i), piece_y, tbl[i].y);
            chk($sformatf("tbl%0d.rot", i), rotation_out, tbl[i].r);
            chk($sformatf("tbl%0d.board", i), board_out, tbl[i].b);
        end

        // bottom row 0xE built up, one cell above it, then the gap filled
        restart();
        startg(0);
        drop(1, 0);
        drop(2, 0);
        drop(3, 0);
        drop(1, 0);
        chk("clr.pre", board_out, 32'hE200_0002);
        drop(0, 0);
        chk("clr.post", board_out, 32'h2000_0002);
        chk("clr.lines", lines_total, 1);

        // command and tick together: move now, fall next cycle, extra tick lost
        restart();
        startg(0);
        cmd_valid = 1'b1; cmd = 2'd1; tick = 1'b1;
        step();
        cmd_valid = 1'b0; tick = 1'b1;
        chk("pend.x", piece_x, 2);
        chk("pend.y0", piece_y, 0);
        step();
        tick = 1'b0;
        chk("pend.y1", piece_y, 1);
        step();
        chk("pend.drop", piece_y, 1);
        chk("pend.board", board_out, 32'h0000_0040);

        // columns 1-2 filled by squares, then a domino cannot spawn
        restart();
        startg(3);
        drop(1, 3);
        drop(1, 3);
        drop(1, 3);
        drop(1, 1);
        chk("go.board", board_out, 32'hFFFF_FFFF);
        chk("go.ready", cmd_ready, 0);
        chk("go.over", game_over, 1);
        cmd_valid = 1'b1; cmd = 2'd0;
        step();
        cmd_valid = 1'b0;
        chk("go.refuse", board_out, 32'hFFFF_FFFF);

        // two full rows, reset lands in the middle of clearing them
        restart();
        startg(3);
        drop(0, 3);
        move(1, 1'b0, 3);
        for (int k = 0; k < 6; k++) move(3, 1'b0, 3);
        cmd_valid = 1'b1; cmd = 2'd3;
        step();
        cmd_valid = 1'b0;
        chk("mid.lock", cmd_ready, 0);
        step();
        chk("mid.landed", landed, 1);
        step();
        chk("mid.lines", lines_total, 1);
        restart_n = 1'b0; start = 1'b1; tick = 1'b1; cmd_valid = 1'b1;
        step();
        chk("mid.board", board_out, 0);
        chk("mid.lines0", lines_total, 0);
        chk("mid.misc", {cmd_ready, game_over, landed, piece_x, piece_y, rotation_out, curr_piece_out}, 0);
        restart_n = 1'b1; start = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
        step();
        chk("mid.idle", {cmd_ready, board_out}, 0);

        // random play against the model
        restart();
        startg(int'($urandom_range(0, 3)));
        for (int i = 0; i < 600; i++) begin
            if (mover) begin
                restart();
                startg(int'($urandom_range(0, 3)));
            end else begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 2) move(3, 1'b1, int'($urandom_range(0, 3)));
                else move(r < 6 ? r - 2 : 3, 1'b0, int'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
